// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: cause width, FSM states and
// the width of the optional periodic timer counter.
package intr_package;

  localparam int CAUSE_W = 4;
  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-side bundle of the interrupt controller: mask programming, status and
// the intr/ack handshake. The controller uses the slave modport.
interface intr_ctrl_if #(
  parameter int NSRC = 4
);
  import intr_package::*;

  logic               mask_we;
  logic [NSRC-1:0]    mask_wdata;
  logic [NSRC-1:0]    mask;
  logic [NSRC-1:0]    pending;
  logic               intr;
  logic [CAUSE_W-1:0] cause;
  logic               ack;

  modport master (
    output mask_we, mask_wdata, ack,
    input  mask, pending, intr, cause
  );

  modport slave (
    input  mask_we, mask_wdata, ack,
    output mask, pending, intr, cause
  );

endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest
// set index, zero-extended to the cause width.
module intr_prio_enc
  import intr_package::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0]    req,
  output logic               valid,
  output logic [CAUSE_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches source pulses, requests the lowest enabled
// pending source from the CPU and waits for ack to drop. INTR_TIMER_EN adds a periodic tick on the top source.
module intr_ctrl
  import intr_package::*;
#(
  parameter int NSRC         = 4,
  parameter int TIMER_PERIOD = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_pulse,
  intr_ctrl_if.slave      bus
);

  state_t             state;
  logic [NSRC-1:0]    mask_q;
  logic [NSRC-1:0]    pending_q;
  logic [NSRC-1:0]    src_eff;
  logic [NSRC-1:0]    clr;
  logic               intr_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               enc_valid;
  logic [CAUSE_W-1:0] enc_idx;

  if (TIMER_PERIOD < 2) begin : g_period_check
    $error("TIMER_PERIOD must be at least 2");
  end

`ifdef INTR_TIMER_EN
  logic [TIMER_W-1:0] tcnt;
  logic               tick;

  assign tick = (tcnt == TIMER_W'(TIMER_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign src_eff = src_pulse | (NSRC'(tick) << (NSRC - 1));
`else
  assign src_eff = src_pulse;
`endif

  intr_prio_enc #(.NSRC(NSRC)) u_enc (
    .req   (pending_q & mask_q),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // The acknowledged source is cleared before new pulses are ORed in, so a
  // pulse landing on the same edge keeps the source pending.
  assign clr = (state == REQ && bus.ack) ? (NSRC'(1) << cause_q) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      intr_q    <= 1'b0;
      cause_q   <= '0;
    end else begin
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      pending_q <= (pending_q & ~clr) | src_eff;
      case (state)
        IDLE: begin
          if (enc_valid) begin
            cause_q <= enc_idx;
            intr_q  <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.ack) begin
            intr_q <= 1'b0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (!bus.ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mask    = mask_q;
  assign bus.pending = pending_q;
  assign bus.intr    = intr_q;
  assign bus.cause   = cause_q;

endmodule
